evm_ballot_unit: RTL and testbench
==================================

// Module: evm_ballot_unit
// PURPOSE
// Ballot unit upstream of the EVM vote counter. Arms one ballot per presiding-officer
// authorisation and synchronises/debounces raw candidate buttons. Emits exactly one
// single-cycle one-hot vote pulse per armed ballot, which drives the counter's vote/enable inputs.
// Blocks double votes, simultaneous presses and stale ballots (timeout).
// PARAMETERS
// NCAND      2     number of candidate buttons (>=2)
// DEB_CYC    4     cycles a button pattern must be stable to be accepted (>=1)
// TMO_CYC    1000  cycles an armed ballot waits before expiring (>=2)
// CW         8     width of ballots_cast counter
// PORTS
// clk            in   1        rising-edge clock
// rst            in   1        asynchronous active-high reset
// poll_open      in   1        1 = polling in progress (counter's voting_status)
// ballot_en      in   1        officer authorisation pulse/level; sampled only in IDLE
// btn            in   NCAND    raw asynchronous candidate buttons, active-high
// ready          out  1        ballot armed, voter may press (lamp)
// vote_pulse     out  NCAND    one-hot, one cycle, accepted vote
// vote_valid     out  1        OR of vote_pulse (counter enable)
// timeout_pulse  out  1        one cycle, armed ballot expired unused
// ballots_cast   out  CW       total accepted votes since reset, saturating
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; all outputs 0; sync/debounce/timers cleared.
// - btn passes 2-flop synchroniser, then debouncer: stable pattern deb_btn updates after
//   DEB_CYC identical consecutive synced samples; deb_chg pulses 1 cycle on update.
// - FSM:
//   IDLE:    ready=0. ballot_en & poll_open & deb_btn==0 -> ARMED, tmo_cnt<=0.
//            ballot_en while any button held is ignored (no arming with stuck key).
//   ARMED:   ready=1. deb_btn one-hot -> CAST (latch choice).
//            deb_btn multi-hot -> stay ARMED, tmo keeps running (rejected, no vote).
//            tmo_cnt==TMO_CYC-1 -> IDLE, timeout_pulse=1 that cycle.
//            !poll_open -> IDLE, no timeout_pulse (priority: poll close > vote > timeout).
//   CAST:    1 cycle. vote_pulse=latched one-hot, vote_valid=1, ready=0,
//            ballots_cast+=1 (holds at 2^CW-1). -> RELEASE.
//   RELEASE: ready=0. deb_btn==0 -> IDLE. Held buttons never produce a second vote.
// - Latency: raw press to vote_pulse = 2 (sync) + DEB_CYC + 1 cycles when ARMED.
// - Press before ARMED held through arming: IDLE refuses to arm; no vote.
// - ballot_en asserted in ARMED/CAST/RELEASE ignored; no queuing.
// - poll_open drop during CAST: pulse still completes (vote already accepted).
// - Outputs registered; vote_pulse never has >1 bit set.
// STRUCTURE
// - Shared pkg evm_pkg: state encoding localparams (IDLE/ARMED/CAST/RELEASE), NCAND default.
// - Sub-module evm_debounce #(W,DEB_CYC): synchroniser + stability counter, outputs
//   deb_btn[W-1:0], deb_chg. Top holds FSM, timeout counter, tally counter.
// TESTING (NCAND=2, DEB_CYC=4, TMO_CYC=20)
// 1 rst; poll_open=1; ballot_en 1 cycle; btn=01 for 10 cycles -> ready=1 then one
//   vote_pulse=01 exactly 7 cycles after press; ballots_cast=1; no 2nd pulse while held.
// 2 armed; btn=11 held 10 cycles then 10 -> no pulse during 11; then vote_pulse=10 once.
// 3 armed, no press 20 cycles -> timeout_pulse once at cycle 20, ready=0, ballots_cast=0.
// 4 btn=01 held, ballot_en -> stays IDLE, ready=0; release, ballot_en -> arms normally.
// 5 btn glitch 01 for 2 cycles while armed -> no vote; poll_open=0 while armed -> IDLE, no tmo.
// 6 rst asserted mid-CAST -> all outputs 0 immediately; preload CW=2, 4 votes -> ballots_cast=3.

Source files
------------

// File: rtl/evm_pkg.sv
// rtl/evm_pkg.sv - shared state encoding, defaults and helpers for the EVM ballot unit
package evm_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_CAST    = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam int unsigned EVM_NCAND = 2;

  // Callers zero-extend their pattern; candidate counts above 32 are not supported.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/evm_debounce.sv
// rtl/evm_debounce.sv - two-flop button synchroniser followed by a stability-count debouncer
module evm_debounce #(
  parameter int unsigned W       = 2,
  parameter int unsigned DEB_CYC = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] btn_i,
  output logic [W-1:0] deb_btn_o,
  output logic         deb_chg_o
);

  localparam int unsigned     CNTW     = $clog2(DEB_CYC + 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEB_CYC);

  logic [W-1:0]    sync1_q;
  logic [W-1:0]    sync2_q;
  logic [W-1:0]    cand_q;
  logic [W-1:0]    cand_d;
  logic [W-1:0]    deb_q;
  logic [W-1:0]    deb_d;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            chg_q;
  logic            chg_d;

  // cnt counts consecutive identical synced samples, saturating once the pattern is trusted.
  always_comb begin
    cand_d = sync2_q;
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    chg_d  = 1'b0;
    if (sync2_q != cand_q) begin
      cnt_d = CNTW'(1);
    end else if (cnt_q != CNT_FULL) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    if ((cnt_d == CNT_FULL) && (sync2_q != deb_q)) begin
      deb_d = sync2_q;
      chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      chg_q   <= chg_d;
    end
  end

  assign deb_btn_o = deb_q;
  assign deb_chg_o = chg_q;

endmodule

// File: rtl/evm_ballot_unit.sv
// rtl/evm_ballot_unit.sv - arms one ballot per authorisation and emits one one-hot vote pulse per ballot
module evm_ballot_unit
  import evm_pkg::*;
#(
  parameter int unsigned NCAND   = EVM_NCAND,
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned TMO_CYC = 1000,
  parameter int unsigned CW      = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             poll_open_i,
  input  logic             ballot_en_i,
  input  logic [NCAND-1:0] btn_i,
  output logic             ready_o,
  output logic [NCAND-1:0] vote_pulse_o,
  output logic             vote_valid_o,
  output logic             timeout_pulse_o,
  output logic [CW-1:0]    ballots_cast_o
);

  localparam int unsigned   TW       = $clog2(TMO_CYC);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_int;
  logic [NCAND-1:0] deb_btn;
  logic             deb_chg;
  logic             deb_any;
  logic             deb_one;

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [TW-1:0]    tmo_q;
  logic [TW-1:0]    tmo_d;
  logic [NCAND-1:0] choice_q;
  logic [NCAND-1:0] choice_d;
  logic [CW-1:0]    cast_q;
  logic [CW-1:0]    cast_d;
  logic             ready_q;
  logic             ready_d;
  logic [NCAND-1:0] pulse_q;
  logic [NCAND-1:0] pulse_d;
  logic             valid_q;
  logic             valid_d;
  logic             tmo_pulse_q;
  logic             tmo_pulse_d;

  // Reset asserts immediately but is released two clocks later, in step with clk.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_sync_q <= 2'b11;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
  end

  assign rst_int = rst_sync_q[1];

  evm_debounce #(
    .W       (NCAND),
    .DEB_CYC (DEB_CYC)
  ) u_debounce (
    .clk_i     (clk_i),
    .rst_i     (rst_int),
    .btn_i     (btn_i),
    .deb_btn_o (deb_btn),
    .deb_chg_o (deb_chg)
  );

  assign deb_any = |deb_btn;
  assign deb_one = is_onehot(32'(deb_btn));

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    choice_d    = choice_q;
    cast_d      = cast_q;
    tmo_pulse_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ballot_en_i && poll_open_i && !deb_any) begin
          state_d = ST_ARMED;
          tmo_d   = '0;
        end
      end
      ST_ARMED: begin
        // Arming needs an idle keypad, so any pattern seen here arrived with a fresh deb_chg.
        if (!poll_open_i) begin
          state_d = ST_IDLE;
        end else if (deb_chg && deb_one) begin
          state_d  = ST_CAST;
          choice_d = deb_btn;
          if (cast_q != '1) begin
            cast_d = cast_q + CW'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d     = ST_IDLE;
          tmo_pulse_d = 1'b1;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_CAST: begin
        state_d = ST_RELEASE;
      end
      default: begin
        if (!deb_any) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    ready_d = (state_d == ST_ARMED);
    valid_d = (state_d == ST_CAST);
    pulse_d = valid_d ? choice_d : '0;
  end

  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      choice_q    <= '0;
      cast_q      <= '0;
      ready_q     <= 1'b0;
      pulse_q     <= '0;
      valid_q     <= 1'b0;
      tmo_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      choice_q    <= choice_d;
      cast_q      <= cast_d;
      ready_q     <= ready_d;
      pulse_q     <= pulse_d;
      valid_q     <= valid_d;
      tmo_pulse_q <= tmo_pulse_d;
    end
  end

  assign ready_o         = ready_q;
  assign vote_pulse_o    = pulse_q;
  assign vote_valid_o    = valid_q;
  assign timeout_pulse_o = tmo_pulse_q;
  assign ballots_cast_o  = cast_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// tb/tb_evm_ballot_unit.sv - directed bench for evm_ballot_unit with a cycle model and literal pins
module tb_evm_ballot_unit;

  localparam int TMO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       poll = 1'b0;
  logic       ben = 1'b0;
  logic [1:0] btn = 2'b00;

  logic       ready8, valid8, tmo8, ready2, valid2, tmo2;
  logic [1:0] pulse8, pulse2;
  logic [7:0] cast8;
  logic [1:0] cast2;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  evm_ballot_unit #(.NCAND(2), .DEB_CYC(4), .TMO_CYC(TMO), .CW(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .poll_open_i(poll), .ballot_en_i(ben), .btn_i(btn),
    .ready_o(ready8), .vote_pulse_o(pulse8), .vote_valid_o(valid8),
    .timeout_pulse_o(tmo8), .ballots_cast_o(cast8)
  );

  evm_ballot_unit #(.NCAND(2), .DEB_CYC(4), .TMO_CYC(TMO), .CW(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .poll_open_i(poll), .ballot_en_i(ben), .btn_i(btn),
    .ready_o(ready2), .vote_pulse_o(pulse2), .vote_valid_o(valid2),
    .timeout_pulse_o(tmo2), .ballots_cast_o(cast2)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: debounced pattern is the raw pattern seen on four consecutive synced samples.
  logic [1:0] hist [0:5];
  logic [1:0] m_deb;
  logic [1:0] e_vote;
  logic       e_tmo;
  bit         m_armed, m_casting, m_wait_rel;
  int         m_age, m_count, hold;

  always @(posedge clk) begin
    if (rst || hold > 0) begin
      if (rst) hold = 2;
      else hold--;
      for (int i = 0; i < 6; i++) hist[i] = 2'b00;
      m_deb = 2'b00; e_vote = 2'b00; e_tmo = 1'b0;
      m_armed = 0; m_casting = 0; m_wait_rel = 0; m_age = 0; m_count = 0;
    end else begin
      e_vote = 2'b00;
      e_tmo  = 1'b0;
      if (m_casting) begin
        m_casting  = 0;
        m_wait_rel = 1;
      end else if (m_wait_rel) begin
        if (m_deb == 2'b00) m_wait_rel = 0;
      end else if (m_armed) begin
        if (!poll) m_armed = 0;
        else if ($countones(m_deb) == 1) begin
          m_armed = 0; m_casting = 1; e_vote = m_deb; m_count++;
        end else if (m_age == TMO - 1) begin
          m_armed = 0; e_tmo = 1'b1;
        end else m_age++;
      end else if (ben && poll && m_deb == 2'b00) begin
        m_armed = 1; m_age = 0;
      end
      for (int i = 5; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = btn;
      if (hist[2] == hist[3] && hist[3] == hist[4] && hist[4] == hist[5]) m_deb = hist[2];
    end
  end

  int n_votes = 0, last_vote_cyc = 0, n_tmo = 0, last_tmo_cyc = 0;
  logic [1:0] last_vote_pat = 2'b00;

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready8", ready8, 0); chk("rst_pulse8", pulse8, 0); chk("rst_valid8", valid8, 0);
      chk("rst_tmo8", tmo8, 0);     chk("rst_cast8", cast8, 0);   chk("rst_cast2", cast2, 0);
    end else begin
      chk("ready8", ready8, m_armed);
      chk("pulse8", pulse8, e_vote);
      chk("valid8", valid8, |e_vote);
      chk("tmo8", tmo8, e_tmo);
      chk("cast8", cast8, (m_count > 255) ? 255 : m_count);
      chk("ready2", ready2, m_armed);
      chk("pulse2", pulse2, e_vote);
      chk("valid2", valid2, |e_vote);
      chk("tmo2", tmo2, e_tmo);
      chk("cast2", cast2, (m_count > 3) ? 3 : m_count);
    end
    if (valid8) begin n_votes++; last_vote_cyc = cyc; last_vote_pat = pulse8; end
    if (tmo8) begin n_tmo++; last_tmo_cyc = cyc; end
  end

  int p, a, v0, t0;

  initial begin
    #1 rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(4);
    chk("reset_ready", ready8, 0);
    chk("reset_cast", cast8, 0);

    // 1: single press, fixed latency, no repeat while held
    poll = 1'b1; ben = 1'b1; tick(1); ben = 1'b0;
    chk("t1_ready", ready8, 1);
    btn = 2'b01; p = cyc; v0 = n_votes; tick(10);
    chk("t1_nvotes", n_votes - v0, 1);
    chk("t1_latency", last_vote_cyc - p, 7);
    chk("t1_pattern", last_vote_pat, 1);
    chk("t1_cast", cast8, 1);
    btn = 2'b00; tick(10);

    // 2: simultaneous press rejected, then single key accepted
    ben = 1'b1; tick(1); ben = 1'b0;
    btn = 2'b11; v0 = n_votes; tick(10);
    chk("t2_no_multi", n_votes - v0, 0);
    chk("t2_still_armed", ready8, 1);
    btn = 2'b10; p = cyc; tick(10);
    chk("t2_nvotes", n_votes - v0, 1);
    chk("t2_latency", last_vote_cyc - p, 7);
    chk("t2_pattern", last_vote_pat, 2);
    btn = 2'b00; tick(10);

    // 3: unused ballot expires
    ben = 1'b1; tick(1); ben = 1'b0;
    a = cyc; t0 = n_tmo; v0 = n_votes; tick(25);
    chk("t3_ntmo", n_tmo - t0, 1);
    chk("t3_tmo_at", last_tmo_cyc - a, 20);
    chk("t3_ready", ready8, 0);
    chk("t3_cast", cast8, 2);
    chk("t3_novote", n_votes - v0, 0);

    // 4: stuck key blocks arming
    btn = 2'b01; tick(8);
    ben = 1'b1; tick(1); ben = 1'b0;
    chk("t4_not_armed", ready8, 0);
    tick(5);
    chk("t4_novote", n_votes - v0, 0);
    btn = 2'b00; tick(8);
    ben = 1'b1; tick(1); ben = 1'b0;
    chk("t4_armed", ready8, 1);

    // 5: short glitch ignored, poll close disarms without timeout
    btn = 2'b01; tick(2); btn = 2'b00; tick(8);
    chk("t5_glitch", n_votes - v0, 0);
    chk("t5_armed", ready8, 1);
    poll = 1'b0; t0 = n_tmo; tick(1);
    chk("t5_closed", ready8, 0);
    tick(25);
    chk("t5_no_tmo", n_tmo - t0, 0);
    poll = 1'b1;

    // 6: reset during CAST, then saturation of the narrow counter
    ben = 1'b1; tick(1); ben = 1'b0;
    btn = 2'b01; tick(7);
    chk("t6_in_cast", valid8, 1);
    chk("t6_cast_pat", pulse8, 1);
    rst = 1'b1; #1;
    chk("t6_rst_valid", valid8, 0);
    chk("t6_rst_pulse", pulse8, 0);
    chk("t6_rst_cast", cast8, 0);
    btn = 2'b00; tick(2);
    rst = 1'b0; tick(4);
    v0 = n_votes;
    for (int k = 0; k < 4; k++) begin
      ben = 1'b1; tick(1); ben = 1'b0;
      btn = (k % 2 == 1) ? 2'b10 : 2'b01;
      tick(10);
      btn = 2'b00; tick(10);
    end
    chk("t6_nvotes", n_votes - v0, 4);
    chk("t6_cast8", cast8, 4);
    chk("t6_cast2_sat", cast2, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
